// File: rtl/traffic_sensor_cond.sv
// Vehicle-detector conditioner: turns raw, asynchronous, bouncy road sensors into clean
// traffic-present levels for the light controller, with a sticky stuck-sensor fault.

module traffic_sensor_chan #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 200,
  parameter int CNT_W        = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic s_i,
  output logic t_o,
  output logic fault_o
);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_QUAL,
    ST_OCCUPIED,
    ST_HOLD,
    ST_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [1:0]       sync_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] stk_q;
  logic             t_q;
  logic             fault_q;
  logic             s;

  assign s = sync_q[1];

  // Outputs are assigned alongside each state transition, so they always reflect
  // the state being entered and carry no decode logic after the flops.
  // NOTE: every register here uses <= so all of them see pre-edge values of each other;
  // a blocking = would let later lines observe already-updated state within the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      stk_q   <= '0;
      t_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], s_i};
      case (state_q)
        ST_EMPTY: begin
          if (s) begin
            state_q <= ST_QUAL;
            cnt_q   <= ONE;
          end
        end
        ST_QUAL: begin
          if (!s) begin
            state_q <= ST_EMPTY;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ST_OCCUPIED;
            stk_q   <= '0;
            t_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_OCCUPIED: begin
          if (!s) begin
            state_q <= ST_HOLD;
            cnt_q   <= ONE;
            stk_q   <= '0;
          end else if (stk_q == STUCK_LAST) begin
            // Fail safe: release the road so the light FSM can serve the other one.
            state_q <= ST_FAULT;
            t_q     <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            stk_q <= stk_q + ONE;
          end
        end
        ST_HOLD: begin
          if (s) begin
            state_q <= ST_OCCUPIED;
            stk_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= ST_EMPTY;
            t_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_EMPTY;
          t_q     <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign t_o     = t_q;
  assign fault_o = fault_q;

endmodule

module traffic_sensor_cond #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 200,
  parameter int CNT_W        = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SA,
  input  logic SB,
  output logic TA,
  output logic TB,
  output logic FAULT_A,
  output logic FAULT_B
);

  traffic_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_a (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .s_i    (SA),
    .t_o    (TA),
    .fault_o(FAULT_A)
  );

  traffic_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_b (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .s_i    (SB),
    .t_o    (TB),
    .fault_o(FAULT_B)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Scoreboard bench for traffic_sensor_cond: a run-length reference model predicts the
// outputs after every edge, and a negedge monitor compares them with the DUT.

module tb_traffic_sensor_cond;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 200;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SA = 1'b0;
  logic SB = 1'b0;
  logic TA, TB, FAULT_A, FAULT_B;

  traffic_sensor_cond #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .STUCK_CYCLES(STUCK),
    .CNT_W       (8)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .SA     (SA),
    .SB     (SB),
    .TA     (TA),
    .TB     (TB),
    .FAULT_A(FAULT_A),
    .FAULT_B(FAULT_B)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic ta;
    logic tb;
    logic fa;
    logic fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 0;
  bit   done    = 0;

  // Reference model: presence follows run lengths of the synchronized samples.
  bit s1[2], s2[2];
  bit present[2], faulted[2];
  int run_hi[2], run_lo[2], entry_run[2];

  task automatic check(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  function automatic void ch_step(input int c, input bit v);
    if (faulted[c]) return;
    if (v) begin
      run_hi[c]++;
      run_lo[c] = 0;
      if (!present[c]) begin
        if (run_hi[c] == DEB) begin
          present[c]   = 1;
          entry_run[c] = run_hi[c];
        end
      end else if (run_hi[c] == 1) begin
        entry_run[c] = 1;  // came back from a short gap
      end else if (run_hi[c] - entry_run[c] == STUCK) begin
        faulted[c] = 1;
        present[c] = 0;
      end
    end else begin
      run_lo[c]++;
      run_hi[c] = 0;
      if (present[c] && run_lo[c] == HOLD) present[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit rst, input bit a, input bit b);
    bit raw[2];
    raw[0] = a;
    raw[1] = b;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        s1[c] = 0; s2[c] = 0;
        present[c] = 0; faulted[c] = 0;
        run_hi[c] = 0; run_lo[c] = 0; entry_run[c] = 0;
      end else begin
        ch_step(c, s2[c]);
        s2[c] = s1[c];
        s1[c] = raw[c];
      end
    end
  endfunction

  always @(posedge CLK) begin
    if (!done) begin
      exp_t e;
      model_edge(RESET, SA, SB);
      e.ta = present[0];
      e.tb = present[1];
      e.fa = faulted[0];
      e.fb = faulted[1];
      exp_q.push_back(e);
      started = 1;
    end
  end

  always @(negedge CLK) begin
    if (started && !done) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("TA", TA, e.ta);
        check("TB", TB, e.tb);
        check("FAULT_A", FAULT_A, e.fa);
        check("FAULT_B", FAULT_B, e.fb);
      end
    end
  end

  task automatic drive(input bit rst, input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      RESET = rst;
      SA    = a;
      SB    = b;
      @(negedge CLK);
    end
  endtask

  initial begin
    bit lvl_a, lvl_b, rst;
    int rem_a, rem_b, rst_rem;

    // Reset with both sensors high, then both roads qualify together.
    drive(1, 1, 1, 3);
    drive(0, 1, 1, 12);
    drive(1, 0, 0, 2);
    // Glitch shorter than the debounce window.
    drive(0, 1, 0, 3);
    drive(0, 0, 0, 10);
    // Arrive, dropout shorter than hold, long drop.
    drive(0, 1, 0, 20);
    drive(0, 0, 0, 5);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 15);
    // Stuck sensor on A, activity ignored afterwards, then reset.
    drive(0, 1, 0, 215);
    for (int i = 0; i < 10; i++) drive(0, i[0], 0, 1);
    drive(1, 0, 0, 1);
    // B in HOLD when reset hits, then requalifies.
    drive(0, 0, 1, 12);
    drive(0, 0, 0, 3);
    drive(1, 0, 0, 1);
    drive(0, 0, 1, 10);
    drive(0, 0, 0, 12);

    // Randomized independent run lengths with rare resets.
    lvl_a = 0; lvl_b = 0; rem_a = 0; rem_b = 0; rst_rem = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rem_a == 0) begin
        lvl_a = ~lvl_a;
        rem_a = ($urandom_range(0, 15) == 0) ? $urandom_range(195, 215) : $urandom_range(1, 12);
      end
      if (rem_b == 0) begin
        lvl_b = ~lvl_b;
        rem_b = ($urandom_range(0, 15) == 0) ? $urandom_range(195, 215) : $urandom_range(1, 12);
      end
      if (rst_rem == 0 && $urandom_range(0, 299) == 0) rst_rem = $urandom_range(1, 2);
      rst = (rst_rem != 0);
      if (rst_rem != 0) rst_rem--;
      drive(rst, lvl_a, lvl_b, 1);
      rem_a--;
      rem_b--;
    end

    drive(0, 0, 0, 2);
    done = 1;
    @(negedge CLK);
    #1;
    if (exp_q.size() > 1) check("scoreboard_drain", 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
